mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, 5, number of busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, 10, number of busy cycles for DIV/DIVU.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  E-stage request; op, A, B valid the same cycle.
REQ-006 Port op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-007 Port A  input  32  rs operand, forwarded value.
REQ-008 Port B  input  32  rt operand, forwarded value.
REQ-009 Port rd_sel  input  1  read select: 0 LO, 1 HI (MFLO/MFHI).
REQ-010 Port out  output  32  selected HI or LO register, combinational mux of registers.
REQ-011 Port busy  output  1  operation in progress; the hazard stall unit stalls D-stage MDU instructions on (busy || start).

Function
REQ-012 The block SHALL implement two states, IDLE and BUSY, plus a down-counter wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-013 In IDLE, start=1 with op 0-3 SHALL latch A, B and op at the edge, enter BUSY and load the counter with the op's cycle count.
REQ-014 busy SHALL be 1 for exactly MULT_CYCLES (MULT/MULTU) or DIV_CYCLES (DIV/DIVU) cycles immediately following the accepting edge, and 0 otherwise.
REQ-015 At the edge ending the last busy cycle, the block SHALL write the result to HI/LO and return to IDLE; out SHALL reflect the new value in the first cycle busy is 0.
REQ-016 HI and LO SHALL hold their previous values throughout BUSY; out SHALL return old values while busy.
REQ-017 MULT SHALL form the signed 64-bit product of A and B; MULTU the unsigned product; HI gets bits 63:32, LO gets bits 31:0.
REQ-018 DIV SHALL yield a signed quotient truncated toward zero in LO and a remainder carrying the dividend's sign in HI; DIVU SHALL yield the unsigned quotient in LO and remainder in HI.
REQ-019 DIV/DIVU with B=0 SHALL still occupy DIV_CYCLES busy cycles and SHALL leave HI and LO unchanged.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-021 MTHI/MTLO with start=1 in IDLE SHALL write A to HI/LO at that edge without asserting busy.
REQ-022 start=1 while busy=1 SHALL be ignored: no latching, no HI/LO write, counter unaffected.
REQ-023 op 6-7 with start=1 SHALL have no effect.
REQ-024 Operands SHALL be taken only from the accepting-edge latch; A/B changes during BUSY SHALL NOT affect the result.

Reset
REQ-025 reset=1 SHALL immediately, independent of clk, force state IDLE, counter 0, HI=0, LO=0, busy=0, out=0.
REQ-026 Reset asserted mid-operation SHALL abort it; no result SHALL be written after reset release.
REQ-027 Whenever reset=1, start SHALL be ignored.

Verification
REQ-028 MULT A=0xFFFFFFFD, B=5 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-029 MULTU A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles.
REQ-030 DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-031 MTHI A=0x12345678, then DIVU A=7, B=0 -> busy 10 cycles; HI stays 0x12345678, LO stays 0.
REQ-032 MULT started, then MTLO A=0xAAAA5555 with start=1 in busy cycle 2 -> MTLO ignored; LO holds MULT result.
REQ-033 DIV started, reset pulsed in busy cycle 4 -> busy=0, HI=LO=0 immediately and after release; no later write.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers; multi-cycle MULT/DIV with a busy
// window, single-cycle MTHI/MTLO, and asynchronous active-high reset.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_sel,
    output logic [31:0] out,
    output logic        busy
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [1:0]    op_q, op_d;

    logic          signed_op;
    logic [63:0]   ext_a, ext_b, prod;
    logic          a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag, quo, rem;

    // op_q[1] selects divide, op_q[0] selects the unsigned variant.
    assign signed_op = ~op_q[0];
    assign ext_a     = {{32{signed_op & a_q[31]}}, a_q};
    assign ext_b     = {{32{signed_op & b_q[31]}}, b_q};
    assign prod      = ext_a * ext_b;

    // Sign-magnitude division: truncates toward zero, remainder follows the
    // dividend, and 0x80000000 / -1 falls out as 0x80000000 remainder 0.
    assign a_neg = signed_op & a_q[31];
    assign b_neg = signed_op & b_q[31];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;
    assign q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
    assign r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
    assign quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem   = a_neg ? -r_mag : r_mag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op[1:0];
                            state_d = S_BUSY;
                            cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        end
                        3'd4:    hi_d = A;
                        3'd5:    lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CW'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (!op_q[1]) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (b_q != '0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_BUSY);
    assign out  = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: hand-computed HI/LO results, busy
// window lengths, ignored requests and asynchronous reset abort.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_sel;
    logic [31:0] out;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .rd_sel(rd_sel),
        .out   (out),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        rd_sel = 1'b1;
        #1;
        check({tag, ".HI"}, out, hi);
        rd_sel = 1'b0;
        #1;
        check({tag, ".LO"}, out, lo);
    endtask

    // Issue a multi-cycle op, optionally presenting a second request in busy
    // cycle inj_cyc; operands are scrambled after the accepting edge.
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b, input int cyc,
                          input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] new_hi, input logic [31:0] new_lo,
                          input int inj_cyc, input logic [2:0] inj_op,
                          input logic [31:0] inj_a);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        A     = ~a;
        B     = b + 32'd1;
        for (int i = 1; i <= cyc; i++) begin
            if (i == inj_cyc) begin
                start = 1'b1;
                op    = inj_op;
                A     = inj_a;
            end
            check({tag, ".busy"}, {31'b0, busy}, 32'd1);
            check_regs({tag, ".old"}, old_hi, old_lo);
            tick();
            start = 1'b0;
        end
        check({tag, ".done"}, {31'b0, busy}, 32'd0);
        check_regs({tag, ".res"}, new_hi, new_lo);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        A      = '0;
        B      = '0;
        rd_sel = 1'b0;
        #2;
        check("rst.busy", {31'b0, busy}, 32'd0);
        check_regs("rst", 32'd0, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        run_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5, 5,
               32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 3'd0, 32'd0);
        run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,
               32'hFFFFFFFF, 32'hFFFFFFF1, 32'hFFFFFFFE, 32'h00000001, 0, 3'd0, 32'd0);
        run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 10,
               32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 3'd0, 32'd0);
        run_op("div_negdivisor", 3'd2, 32'd7, 32'hFFFFFFFE, 10,
               32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFD, 0, 3'd0, 32'd0);
        run_op("divu", 3'd3, 32'd100, 32'd7, 10,
               32'd1, 32'hFFFFFFFD, 32'd2, 32'd14, 0, 3'd0, 32'd0);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10,
               32'd2, 32'd14, 32'd0, 32'h80000000, 0, 3'd0, 32'd0);

        start = 1'b1;
        op    = 3'd4;
        A     = 32'h12345678;
        tick();
        check("mthi.busy", {31'b0, busy}, 32'd0);
        op = 3'd5;
        A  = 32'd0;
        tick();
        start = 1'b0;
        check("mtlo.busy", {31'b0, busy}, 32'd0);
        check_regs("mthi_mtlo", 32'h12345678, 32'd0);

        start = 1'b1;
        op    = 3'd6;
        A     = 32'hDEADBEEF;
        B     = 32'd3;
        tick();
        op = 3'd7;
        tick();
        start = 1'b0;
        check("nop.busy", {31'b0, busy}, 32'd0);
        check_regs("nop", 32'h12345678, 32'd0);

        run_op("divu_zero", 3'd3, 32'd7, 32'd0, 10,
               32'h12345678, 32'd0, 32'h12345678, 32'd0, 0, 3'd0, 32'd0);
        run_op("mult_mtlo", 3'd0, 32'd3, 32'd4, 5,
               32'h12345678, 32'd0, 32'd0, 32'd12, 2, 3'd5, 32'hAAAA5555);

        start = 1'b1;
        op    = 3'd2;
        A     = 32'd100;
        B     = 32'd3;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check("abort.busy", {31'b0, busy}, 32'd1);
            tick();
        end
        reset = 1'b1;
        start = 1'b1;
        op    = 3'd4;
        A     = 32'h0000FFFF;
        #1;
        check("abort.rst_busy", {31'b0, busy}, 32'd0);
        check_regs("abort.rst", 32'd0, 32'd0);
        tick();
        tick();
        check_regs("abort.hold", 32'd0, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("abort.after_busy", {31'b0, busy}, 32'd0);
        end
        check_regs("abort.after", 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
